// File: rtl/emu_ram_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : emu_ram_scan_ctrl
// Brief    : Host-side RAM scan-chain sequencer for save/load of DUT memories.
// Revision : 1.0 - initial release
// ============================================================================
module emu_ram_scan_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dut_paused,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_dir,
    input  logic [CNT_WIDTH-1:0]  cmd_len,
    output logic                  ram_se,
    output logic                  ram_sd,
    output logic [DATA_WIDTH-1:0] ram_di,
    input  logic [DATA_WIDTH-1:0] ram_do,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SAVE  = 3'd1,
        S_DRAIN = 3'd2,
        S_LOAD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    rem_q, rem_d;
    logic                    sd_q, sd_d;
    logic [DATA_WIDTH-1:0]   obuf_q, obuf_d;
    logic                    ofull_q, ofull_d;
    logic                    se;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            sd_q    <= 1'b0;
            obuf_q  <= '0;
            ofull_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sd_q    <= sd_d;
            obuf_q  <= obuf_d;
            ofull_q <= ofull_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        sd_d      = sd_q;
        obuf_d    = obuf_q;
        ofull_d   = ofull_q;
        cmd_ready = 1'b0;
        se        = 1'b0;
        in_ready  = 1'b0;
        ram_di    = '0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = dut_paused;
                if (cmd_valid && dut_paused) begin
                    rem_d = cmd_len;
                    sd_d  = cmd_dir;
                    if (cmd_len == '0) begin
                        state_d = S_DONE;
                    end else if (cmd_dir) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_SAVE;
                    end
                end
            end

            S_SAVE: begin
                // Advance the chain only when the output register can take the word.
                se = (rem_q != '0) && (!ofull_q || out_ready);
                if (se) begin
                    obuf_d  = ram_do;
                    ofull_d = 1'b1;
                    rem_d   = rem_q - C_ONE;
                    if (rem_q == C_ONE) begin
                        state_d = S_DRAIN;
                    end
                end else if (out_ready && ofull_q) begin
                    ofull_d = 1'b0;
                end
                if (rem_q == '0) begin
                    state_d = S_DRAIN;
                end
            end

            S_DRAIN: begin
                if (out_ready && ofull_q) begin
                    ofull_d = 1'b0;
                end
                // Leave as the last word is handed off so done lands one cycle later.
                if (!ofull_q || out_ready) begin
                    state_d = S_DONE;
                end
            end

            S_LOAD: begin
                in_ready = 1'b1;
                ram_di   = in_data;
                se       = in_valid && (rem_q != '0);
                if (se) begin
                    rem_d = rem_q - C_ONE;
                    if (rem_q == C_ONE) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ram_se    = se;
    assign ram_sd    = sd_q;
    assign out_valid = ofull_q;
    assign out_data  = obuf_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule
`default_nettype wire
